seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
- Sits directly upstream of the 3-to-8 active-low decoder: drives its 3-bit select and 2-bit enable (enable bit 1 active-high, bit 0 active-low), and in the same cycle drives the matching segment pattern.
- Cycles through the digits at a programmable rate, with a short blanking gap between digits to suppress ghosting.
- Latches a 32-bit hex value once per frame, so the display never shows a mix of old and new digits.

Parameters:
- DIV, 100000: clock cycles each digit is lit (SHOW phase); legal range ≥2.
- BLANK, 16: clock cycles the decoder is disabled between digits; legal range ≥1.
- NUM_DIGITS, 8: number of scanned digits; legal range 1..8.

Ports:
- iClk  input  1  system clock.
- iRst_n  input  1  asynchronous active-low reset.
- iEn  input  1  scan enable; low forces IDLE.
- iValue  input  32  eight hex nibbles; nibble k (bits 4k+3:4k) is shown on digit k.
- iDigitMask  input  8  bit k = 1 blanks digit k.
- iDp  input  8  bit k = 1 lights the decimal point of digit k.
- oSel  output  3  digit index, to the decoder's 3-bit data input.
- oEna  output  2  decoder enable: 2'b10 = enabled, 2'b01 = disabled.
- oSeg  output  8  active-low segments, {dp,g,f,e,d,c,b,a}.
- oFrame  output  1  one-cycle pulse at the start of each frame (digit 0 entering SHOW).

Behaviour:
- Reset (async assert, sync release):
  - oSel=0, oEna=2'b01, oSeg=8'hFF, oFrame=0.
  - Prescaler=0, state=IDLE, latched value=0.
- All outputs are registered. Outputs change one cycle after the state and counter changes that cause them.
- States:
  - IDLE:
    - Outputs: oEna=2'b01, oSeg=8'hFF.
    - iEn=1 → SHOW with index 0. Latch iValue/iDp; prescaler=0; pulse oFrame.
  - SHOW:
    - Outputs: oSel=index; oEna=2'b10 unless iDigitMask[index]=1, in which case oEna=2'b01.
    - oSeg=hex7seg(latched nibble) with dp bit = ~latchedDp[index]. A masked digit shows oSeg=8'hFF.
    - Prescaler counts 0..DIV-1. At DIV-1 → BLANK and prescaler=0.
  - BLANK:
    - Outputs: oEna=2'b01, oSeg=8'hFF, oSel holds the old index.
    - At BLANK-1 → SHOW; index advances.
    - Wrap: when index=NUM_DIGITS-1, index wraps to 0, iValue/iDp are re-latched, and oFrame pulses.
- iEn=0 in any state → IDLE on the next cycle. Prescaler and index reset to 0. Re-enabling starts a fresh frame at digit 0.
- iDigitMask is sampled live every cycle, not latched.
- Hex encoding, active-low, dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - With dp lit, bit 7 is cleared.
- NUM_DIGITS=1: the scan alternates SHOW/BLANK on digit 0, and oFrame pulses every SHOW entry.
- Frame period = NUM_DIGITS*(DIV+BLANK) cycles.
- The enable is never 2'b10 during BLANK or IDLE. This guarantees the downstream decoder outputs all 1s (no anode on) when the segments are invalid.

Decomposition:
- Shared package seg_pkg:
  - Constants EN_ON=2'b10, EN_OFF=2'b01, SEG_OFF=8'hFF.
  - The 16-entry hex-to-segment constant table.
  - State enum {IDLE, SHOW, BLANK}.
- Natural sub-module: hex7seg (combinational nibble → 7-bit active-low pattern), instantiated once.
- The top module owns the FSM, prescaler, index counter and frame latch.

Test Plan (DIV=4, BLANK=2, NUM_DIGITS=8 unless noted):
- Reset release with iEn=0 → oEna=2'b01 and oSeg=8'hFF held indefinitely; oFrame never pulses.
- iEn=1, iValue=32'h76543210, mask=0, dp=0:
  - Digit 0 lit 4 cycles with oSel=0, oSeg=C0, oEna=2'b10.
  - Then 2 cycles with oEna=2'b01.
  - Then oSel=1, oSeg=F9.
  - oFrame pulses every 48 cycles.
- iValue changes mid-frame from 32'h00000000 to 32'hFFFFFFFF:
  - Remaining digits of the current frame still show C0.
  - The next frame shows 8E on every digit.
- iDigitMask=8'h04, iDp=8'h01:
  - Digit 0 shows oSeg=40.
  - Digit 2 keeps oEna=2'b01 and oSeg=FF for its whole slot.
  - Other digits are unaffected.
- iEn dropped during digit 5 SHOW:
  - Next cycle: oEna=2'b01, oSeg=FF.
  - Re-assert: restart at oSel=0 with an oFrame pulse.
- Async iRst_n pulse mid-SHOW, not clock-aligned → outputs reach reset values immediately; NUM_DIGITS=3 run wraps oSel 0→1→2→0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, state encoding and hex-to-segment table for the
// seven-segment scan controller.
`timescale 1ns/1ps
package seg_pkg;

   localparam logic [1:0] EN_ON   = 2'b10;
   localparam logic [1:0] EN_OFF  = 2'b01;
   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F.
   localparam logic [6:0] HEX_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_BLANK
   } scanState_e;

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern (no dp).
`timescale 1ns/1ps
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] iNibble,
   output logic [6:0] oSegs
);

   assign oSegs = HEX_TABLE[iNibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display,
// driving a 3-to-8 active-low decoder with a blanking gap between digits.
`timescale 1ns/1ps
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIV        = 100000,
   parameter int BLANK      = 16,
   parameter int NUM_DIGITS = 8
)(
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic        iEn,
   input  logic [31:0] iValue,
   input  logic [7:0]  iDigitMask,
   input  logic [7:0]  iDp,
   output logic [2:0]  oSel,
   output logic [1:0]  oEna,
   output logic [7:0]  oSeg,
   output logic        oFrame
);

   localparam int CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
   localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

   scanState_e  stateQ, stateD;
   logic [CW-1:0] cntQ, cntD;
   logic [2:0]  idxQ, idxD;
   logic [31:0] valueQ, valueD;
   logic [7:0]  dpQ, dpD;
   logic        frameStartQ, frameStartD;

   logic [2:0]  selQ, selD;
   logic [1:0]  enaQ, enaD;
   logic [7:0]  segQ, segD;
   logic        frameQ, frameD;

   logic [3:0]  nibble;
   logic [6:0]  hexSegs;

   assign nibble = valueQ[{idxQ, 2'b00} +: 4];

   hex7seg uHex (
      .iNibble (nibble),
      .oSegs   (hexSegs)
   );

   // Frame latch happens only on entry to digit 0, so a frame never mixes values.
   always_comb begin
      stateD      = stateQ;
      cntD        = cntQ;
      idxD        = idxQ;
      valueD      = valueQ;
      dpD         = dpQ;
      frameStartD = 1'b0;
      case (stateQ)
         ST_IDLE: begin
            if (iEn) begin
               stateD      = ST_SHOW;
               cntD        = '0;
               idxD        = '0;
               valueD      = iValue;
               dpD         = iDp;
               frameStartD = 1'b1;
            end
         end
         ST_SHOW: begin
            if (cntQ == SHOW_LAST) begin
               stateD = ST_BLANK;
               cntD   = '0;
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
         ST_BLANK: begin
            if (cntQ == BLANK_LAST) begin
               stateD = ST_SHOW;
               cntD   = '0;
               if (idxQ == LAST_IDX) begin
                  idxD        = '0;
                  valueD      = iValue;
                  dpD         = iDp;
                  frameStartD = 1'b1;
               end else begin
                  idxD = idxQ + 1'b1;
               end
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
         default: stateD = ST_IDLE;
      endcase
      if (!iEn) begin
         stateD      = ST_IDLE;
         cntD        = '0;
         idxD        = '0;
         frameStartD = 1'b0;
      end
   end

   // Dropping iEn blanks at the very next edge so the decoder is never left lit.
   always_comb begin
      selD   = idxQ;
      enaD   = EN_OFF;
      segD   = SEG_OFF;
      frameD = frameStartQ & iEn;
      if (iEn && (stateQ == ST_SHOW) && !iDigitMask[idxQ]) begin
         enaD = EN_ON;
         segD = {~dpQ[idxQ], hexSegs};
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         stateQ      <= ST_IDLE;
         cntQ        <= '0;
         idxQ        <= '0;
         valueQ      <= '0;
         dpQ         <= '0;
         frameStartQ <= 1'b0;
         selQ        <= '0;
         enaQ        <= EN_OFF;
         segQ        <= SEG_OFF;
         frameQ      <= 1'b0;
      end else begin
         stateQ      <= stateD;
         cntQ        <= cntD;
         idxQ        <= idxD;
         valueQ      <= valueD;
         dpQ         <= dpD;
         frameStartQ <= frameStartD;
         selQ        <= selD;
         enaQ        <= enaD;
         segQ        <= segD;
         frameQ      <= frameD;
      end
   end

   assign oSel   = selQ;
   assign oEna   = enaQ;
   assign oSeg   = segQ;
   assign oFrame = frameQ;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues per-cycle expected
// outputs, monitors on the falling edge pop and compare them.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

   typedef struct {
      logic [2:0] sel;
      logic [1:0] ena;
      logic [7:0] seg;
      logic       frame;
      int         tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstN = 1'b1;
   logic        en = 1'b0;
   logic        en3 = 1'b0;
   logic [31:0] value = 32'h0;
   logic [7:0]  mask = 8'h00;
   logic [7:0]  dp = 8'h00;

   logic [2:0]  sel8, sel3;
   logic [1:0]  ena8, ena3;
   logic [7:0]  seg8, seg3;
   logic        frame8, frame3;

   exp_t q8[$];
   exp_t q3[$];
   int   checkCount = 0;
   int   passCount = 0;
   int   testId = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIV(4), .BLANK(2), .NUM_DIGITS(8)) dut (
      .iClk       (clk),
      .iRst_n     (rstN),
      .iEn        (en),
      .iValue     (value),
      .iDigitMask (mask),
      .iDp        (dp),
      .oSel       (sel8),
      .oEna       (ena8),
      .oSeg       (seg8),
      .oFrame     (frame8)
   );

   seg_scan_ctrl #(.DIV(4), .BLANK(2), .NUM_DIGITS(3)) dut3 (
      .iClk       (clk),
      .iRst_n     (rstN),
      .iEn        (en3),
      .iValue     (value),
      .iDigitMask (mask),
      .iDp        (dp),
      .oSel       (sel3),
      .oEna       (ena3),
      .oSeg       (seg3),
      .oFrame     (frame3)
   );

   function automatic logic [7:0] hexSeg(input int n);
      case (n)
         0: return 8'hC0;   1: return 8'hF9;   2: return 8'hA4;   3: return 8'hB0;
         4: return 8'h99;   5: return 8'h92;   6: return 8'h82;   7: return 8'hF8;
         8: return 8'h80;   9: return 8'h90;  10: return 8'h88;  11: return 8'h83;
        12: return 8'hC6;  13: return 8'hA1;  14: return 8'h86;  15: return 8'h8E;
         default: return 8'hXX;
      endcase
   endfunction

   task automatic checkOutput(input string name, input exp_t e, input logic [2:0] s,
                              input logic [1:0] a, input logic [7:0] g, input logic f);
      checkCount++;
      if (s === e.sel && a === e.ena && g === e.seg && f === e.frame) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s test%0d: got sel=%0d ena=%b seg=%h frame=%b, expected sel=%0d ena=%b seg=%h frame=%b",
                  name, e.tag, s, a, g, f, e.sel, e.ena, e.seg, e.frame);
      end
   endtask

   always @(negedge clk) begin
      if (q8.size() > 0) checkOutput("dut8", q8.pop_front(), sel8, ena8, seg8, frame8);
   end

   always @(negedge clk) begin
      if (q3.size() > 0) checkOutput("dut3", q3.pop_front(), sel3, ena3, seg3, frame3);
   end

   task automatic pushExp(input bit toThree, input logic [2:0] s, input logic [1:0] a,
                          input logic [7:0] g, input logic f);
      exp_t e;
      e.sel = s; e.ena = a; e.seg = g; e.frame = f; e.tag = testId;
      if (toThree) q3.push_back(e);
      else         q8.push_back(e);
   endtask

   task automatic pushOff(input bit toThree, input logic [2:0] s, input int n);
      for (int i = 0; i < n; i++) pushExp(toThree, s, 2'b01, 8'hFF, 1'b0);
   endtask

   // One digit slot: 4 SHOW cycles then 2 BLANK cycles holding the index.
   task automatic pushDigit(input bit toThree, input logic [2:0] s, input logic [7:0] g,
                            input logic f, input bit masked);
      for (int i = 0; i < 4; i++) begin
         if (masked) pushExp(toThree, s, 2'b01, 8'hFF, (i == 0) ? f : 1'b0);
         else        pushExp(toThree, s, 2'b10, g, (i == 0) ? f : 1'b0);
      end
      pushOff(toThree, s, 2);
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #2;
   endtask

   task automatic goIdle();
      en = 1'b0;
      applyStimulus(3);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #1 rstN = 1'b0;
      repeat (2) @(posedge clk);
      #2 rstN = 1'b1;

      // Reset values, then idle with en low: never lit, no frame pulse.
      testId = 1;
      pushOff(0, 3'd0, 12);
      applyStimulus(12);

      // Plain scan of 76543210, one full frame plus the next frame start.
      testId = 2;
      value = 32'h76543210; en = 1'b1;
      pushOff(0, 3'd0, 2);
      for (int k = 0; k < 8; k++) pushDigit(0, 3'(k), hexSeg(k), k == 0, 0);
      pushDigit(0, 3'd0, hexSeg(0), 1'b1, 0);
      applyStimulus(56);
      goIdle();

      // Value changes mid-frame: current frame keeps the old latch.
      testId = 3;
      value = 32'h00000000; en = 1'b1;
      pushOff(0, 3'd0, 2);
      for (int k = 0; k < 3; k++) pushDigit(0, 3'(k), 8'hC0, k == 0, 0);
      applyStimulus(20);
      value = 32'hFFFFFFFF;
      for (int k = 3; k < 8; k++) pushDigit(0, 3'(k), 8'hC0, 1'b0, 0);
      for (int k = 0; k < 8; k++) pushDigit(0, 3'(k), 8'h8E, k == 0, 0);
      applyStimulus(78);
      goIdle();

      // Digit 2 masked, decimal point on digit 0.
      testId = 4;
      value = 32'h76543210; mask = 8'h04; dp = 8'h01; en = 1'b1;
      pushOff(0, 3'd0, 2);
      for (int k = 0; k < 8; k++)
         pushDigit(0, 3'(k), (k == 0) ? 8'h40 : hexSeg(k), k == 0, k == 2);
      applyStimulus(50);
      goIdle();
      mask = 8'h00; dp = 8'h00;

      // Enable dropped during digit 5 SHOW, then re-asserted.
      testId = 5;
      en = 1'b1;
      pushOff(0, 3'd0, 2);
      for (int k = 0; k < 5; k++) pushDigit(0, 3'(k), hexSeg(k), k == 0, 0);
      pushExp(0, 3'd5, 2'b10, hexSeg(5), 1'b0);
      pushExp(0, 3'd5, 2'b10, hexSeg(5), 1'b0);
      applyStimulus(34);
      en = 1'b0;
      pushExp(0, 3'd5, 2'b10, hexSeg(5), 1'b0);
      pushOff(0, 3'd5, 1);
      pushOff(0, 3'd0, 3);
      applyStimulus(5);
      testId = 6;
      en = 1'b1;
      pushOff(0, 3'd0, 2);
      pushDigit(0, 3'd0, hexSeg(0), 1'b1, 0);
      applyStimulus(8);
      goIdle();

      // Asynchronous reset asserted between clock edges while digit 0 is lit.
      testId = 7;
      en = 1'b1;
      pushOff(0, 3'd0, 2);
      pushExp(0, 3'd0, 2'b10, hexSeg(0), 1'b1);
      pushExp(0, 3'd0, 2'b10, hexSeg(0), 1'b0);
      repeat (4) @(posedge clk);
      #3 rstN = 1'b0;
      #1;
      begin
         exp_t r;
         r.sel = 3'd0; r.ena = 2'b01; r.seg = 8'hFF; r.frame = 1'b0; r.tag = testId;
         checkOutput("asyncReset", r, sel8, ena8, seg8, frame8);
      end
      en = 1'b0;
      repeat (2) @(posedge clk);
      #2 rstN = 1'b1;
      applyStimulus(3);

      // Three-digit instance wraps 0 -> 1 -> 2 -> 0 with a frame pulse each wrap.
      testId = 8;
      en3 = 1'b1;
      pushOff(1, 3'd0, 2);
      for (int k = 0; k < 3; k++) pushDigit(1, 3'(k), hexSeg(k), k == 0, 0);
      pushDigit(1, 3'd0, hexSeg(0), 1'b1, 0);
      pushDigit(1, 3'd1, hexSeg(1), 1'b0, 0);
      applyStimulus(32);
      en3 = 1'b0;
      applyStimulus(2);

      if (q8.size() != 0 || q3.size() != 0) begin
         checkCount++;
         $display("[TB] FAIL drain: got %0d/%0d entries left, expected 0/0", q8.size(), q3.size());
      end
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
